// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit producing a Hi/Lo pair for the multicycle datapath.
// Optional build macro MULDIV_UNSIGNED_EN adds an `uns` input for multu/divu semantics.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             uns,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               dz_op_q, dz_op_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;

  logic               uns_s;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
`ifdef MULDIV_UNSIGNED_EN
    uns_s = uns;
`else
    uns_s = 1'b0;
`endif
    sign_a = a[WIDTH-1] & ~uns_s;
    sign_b = b[WIDTH-1] & ~uns_s;
    mag_a  = sign_a ? ('0 - a) : a;
    mag_b  = sign_b ? ('0 - b) : b;
  end

  // Accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, mag_b_q};
    if (div_sh >= {1'b0, mag_b_q}) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod_neg = '0 - acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    dz_op_d    = dz_op_q;
    mag_b_d    = mag_b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          neg_a_d = sign_a;
          neg_b_d = sign_b;
          mag_b_d = mag_b;
          acc_d   = {{WIDTH{1'b0}}, mag_a};
          cnt_d   = CNT_W'(WIDTH);
          dz_op_d = 1'b0;
          if (op && (b == '0)) begin
            // Divide-by-zero skips the iterations but still passes through FIX
            // (without writing hi/lo) so done lands two cycles after start.
            dz_op_d    = 1'b1;
            div_zero_d = 1'b1;
            state_d    = S_FIX;
          end else if (op) begin
            div_zero_d = 1'b0;
            state_d    = S_DIV;
          end else begin
            state_d    = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!dz_op_q) begin
          if (!op_q) begin
            {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : acc_q;
          end else begin
            lo_d = (neg_a_q ^ neg_b_q) ? ('0 - quo) : quo;
            hi_d = neg_a_q ? ('0 - rem) : rem;
          end
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      dz_op_q    <= 1'b0;
      mag_b_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      dz_op_q    <= dz_op_d;
      mag_b_q    <= mag_b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, corner sequences, randomized ops
// against an arithmetic reference model, plus a WIDTH=8 instance.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a, b;
  logic        uns;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8, op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_hi = '0, exp_lo = '0;
  bit          exp_dz = 1'b0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
`ifdef MULDIV_UNSIGNED_EN
    .uns(uns),
`endif
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
`ifdef MULDIV_UNSIGNED_EN
    .uns(1'b0),
`endif
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    bit          op;
    logic [31:0] a, b, hi, lo;
    bit          dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] ref_model(input bit o, input logic [31:0] aa, input logic [31:0] bb,
                                            input bit uu);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    ua = {32'b0, aa};
    ub = {32'b0, bb};
    if (!o) begin
      res = uu ? (ua * ub) : 64'(sa * sb);
    end else if (uu) begin
      res = {32'(ua % ub), 32'(ua / ub)};
    end else begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  function automatic logic [15:0] ref8(input bit o, input logic [7:0] aa, input logic [7:0] bb);
    int sa, sb, p;
    sa = int'($signed(aa));
    sb = int'($signed(bb));
    if (!o) begin
      p = sa * sb;
      return p[15:0];
    end
    p = sa / sb;
    sa = sa % sb;
    return {sa[7:0], p[7:0]};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom % 8)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'($urandom % 16) - 32'd8;
      default: return $urandom;
    endcase
  endfunction

  // Runs one operation, scrambling a/b/op after the start edge; optionally pokes start
  // mid-operation (poke_k) and in the done cycle (poke_done). Updates the reference model.
  task automatic run_op(input bit o, input logic [31:0] aa, input logic [31:0] bb, input bit uu,
                        input int poke_k, input bit poke_done,
                        output logic [31:0] rhi, output logic [31:0] rlo, output bit rdz,
                        output int lat, output int bcnt);
    logic [63:0] r;
    @(negedge clk);
    op = o; a = aa; b = bb; uns = uu; start = 1'b1;
    lat = -1;
    bcnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; a = $urandom; b = $urandom; op = ~o;
      end
      if (poke_k != 0 && k == poke_k) begin
        start = 1'b1; a = 32'd1; b = 32'd1;
      end else if (poke_k != 0 && k == poke_k + 1) begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    rhi = hi; rlo = lo; rdz = div_zero;
    if (o && bb == '0) begin
      exp_dz = 1'b1;
    end else begin
      r = ref_model(o, aa, bb, uu);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      if (o) exp_dz = 1'b0;
    end
    if (poke_done) begin
      start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_busy", {63'b0, busy}, 64'd0);
      check("start_in_done_done", {63'b0, done}, 64'd0);
    end
  endtask

  task automatic run8(input bit o, input logic [7:0] aa, input logic [7:0] bb,
                      output logic [7:0] rhi, output logic [7:0] rlo, output int lat);
    @(negedge clk);
    op8 = o; a8 = aa; b8 = bb; start8 = 1'b1;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      if (done8) begin
        lat = k;
        break;
      end
    end
    rhi = hi8; rlo = lo8;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[15];
    logic [31:0] rhi, rlo;
    logic [7:0]  h8, l8;
    logic [15:0] e8;
    bit          rdz, o, uu;
    int          lat, bcnt, dpulse;
    logic [31:0] ra, rb;
    logic [7:0]  ra8, rb8;

    vt[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vt[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vt[2]  = '{1'b1, 32'd95,         32'd10,        32'd5,         32'd9,         1'b0};
    vt[3]  = '{1'b1, 32'd100,        32'd0,         32'd5,         32'd9,         1'b1};
    vt[4]  = '{1'b1, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0};
    vt[5]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
    vt[6]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vt[7]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'd1,         1'b0};
    vt[8]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};
    vt[9]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vt[10] = '{1'b1, 32'd1,          32'd0,         32'd1,         32'hFFFF_FFFD, 1'b1};
    vt[11] = '{1'b0, 32'd2,          32'd3,         32'd0,         32'd6,         1'b1};
    vt[12] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b1};
    vt[13] = '{1'b1, 32'd6,          32'd3,         32'd0,         32'd2,         1'b0};
    vt[14] = '{1'b1, 32'd3,          32'd7,         32'd3,         32'd0,         1'b0};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; uns = 1'b0;
    start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_dz",   {63'b0, div_zero}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, 1'b0, 0, 1'b0, rhi, rlo, rdz, lat, bcnt);
      check($sformatf("vec%0d_lat", i), 64'(lat), vt[i].dz && vt[i].op && vt[i].b == 0 ? 64'd2 : 64'd34);
      check($sformatf("vec%0d_hi", i), {32'b0, rhi}, {32'b0, vt[i].hi});
      check($sformatf("vec%0d_lo", i), {32'b0, rlo}, {32'b0, vt[i].lo});
      check($sformatf("vec%0d_dz", i), {63'b0, rdz}, {63'b0, vt[i].dz});
      if (!(vt[i].op && vt[i].b == 0))
        check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd33);
    end

`ifdef MULDIV_UNSIGNED_EN
    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 0, 1'b0, rhi, rlo, rdz, lat, bcnt);
    check("multu_hilo", {rhi, rlo}, 64'h0000_0001_FFFF_FFFE);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, rhi, rlo, rdz, lat, bcnt);
    check("divu_hilo", {rhi, rlo}, 64'h8000_0000_0000_0000);
`endif

    run_op(1'b0, 32'd6, 32'd7, 1'b0, 5, 1'b1, rhi, rlo, rdz, lat, bcnt);
    check("poke_lat",  64'(lat), 64'd34);
    check("poke_hilo", {rhi, rlo}, 64'd42);

    // Abort a multiply with reset mid-iteration.
    @(negedge clk);
    op = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("abort_busy_before", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_dz",   {63'b0, div_zero}, 64'd0);
    dpulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dpulse++;
    end
    check("abort_no_done", 64'(dpulse), 64'd0);
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;

    for (int i = 0; i < 200; i++) begin
      o = 1'($urandom);
      ra = rnd32();
      rb = rnd32();
`ifdef MULDIV_UNSIGNED_EN
      uu = 1'($urandom);
`else
      uu = 1'b0;
`endif
      run_op(o, ra, rb, uu, 0, 1'b0, rhi, rlo, rdz, lat, bcnt);
      check($sformatf("rnd%0d_lat", i), 64'(lat), (o && rb == 0) ? 64'd2 : 64'd34);
      check($sformatf("rnd%0d_hilo", i), {rhi, rlo}, {exp_hi, exp_lo});
      check($sformatf("rnd%0d_dz", i), {63'b0, rdz}, {63'b0, exp_dz});
    end

    run8(1'b0, 8'h80, 8'hFF, h8, l8, lat);
    check("w8_lat",  64'(lat), 64'd10);
    check("w8_hilo", {48'b0, h8, l8}, 64'h0080);
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom);
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      if (i % 5 == 0) ra8 = 8'h80;
      if (rb8 == 0) rb8 = 8'hFF;
      run8(o, ra8, rb8, h8, l8, lat);
      e8 = ref8(o, ra8, rb8);
      check($sformatf("w8rnd%0d_lat", i), 64'(lat), 64'd10);
      check($sformatf("w8rnd%0d_hilo", i), {48'b0, h8, l8}, {48'b0, e8});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
